// File: rtl/piso_pkg.sv
// Shared constants for the parallel-in/serial-out serializer.
package piso_pkg;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_FIFO_DEPTH = 4;

    // One-hot shifter states
    localparam logic [1:0] S_IDLE  = 2'b01;
    localparam logic [1:0] S_SHIFT = 2'b10;
endpackage

// File: rtl/sync_fifo.sv
// Plain synchronous FIFO: push/pop are trusted, no handshake logic here.
module sync_fifo
    import piso_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally because the depth is a power of two
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
endmodule

// File: rtl/piso_serializer.sv
// Parallel words in through a FIFO, shifted out one bit per serial beat.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int MSB_FIRST  = 1,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              data_o,
    output logic              valid_o,
    output logic              last_o,
    input  logic              ready_i,
    output logic [CNT_W-1:0]  fill_o,
    output logic              busy_o
);
    localparam int              BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(DATA_W - 1);

    logic [1:0]        state;
    logic [BIT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              busy;
    logic              beat;
    logic              last_bit;
    logic [BIT_W-1:0]  bit_idx;

    // ready_o comes from the registered count only, so a full FIFO never
    // accepts a word even if a pop happens in the same cycle
    assign ready_o  = rst_i & ~fifo_full;
    assign push     = valid_i & ready_o;
    assign busy     = (state == S_SHIFT);
    assign last_bit = (cnt == LAST_IDX);
    assign beat     = busy & ready_i;
    // Reload straight from the last beat keeps back-to-back words gap-free
    assign pop      = ~fifo_empty & ((state == S_IDLE) | (beat & last_bit));
    assign bit_idx  = (MSB_FIRST != 0) ? (LAST_IDX - cnt) : cnt;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (push),
        .pop     (pop),
        .wr_data (data_i),
        .rd_data (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Shifter FSM: load from FIFO head, advance bit counter on each beat
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        shreg <= fifo_head;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (beat) begin
                        if (!last_bit) begin
                            cnt <= cnt + BIT_W'(1);
                        end else if (!fifo_empty) begin
                            shreg <= fifo_head;
                            cnt   <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs come from registered state; rst_i forces them quiet while held
    assign valid_o = rst_i & busy;
    assign data_o  = rst_i & busy & shreg[bit_idx];
    assign last_o  = rst_i & busy & last_bit;
    assign busy_o  = rst_i & busy;
    assign fill_o  = rst_i ? fifo_count : '0;
endmodule

// File: tb/tb_piso_serializer.sv
// Randomized and directed checks of piso_serializer in both bit orders.
module tb_piso_serializer;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [W-1:0]  din = '0;
    logic          vin = 1'b0;
    logic          rdy = 1'b0;

    logic          m_ready, m_data, m_valid, m_last, m_busy;
    logic [CW-1:0] m_fill;
    logic          l_ready, l_data, l_valid, l_last, l_busy;
    logic [CW-1:0] l_fill;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: words waiting, word being sent, position in it
    logic [W-1:0] fq[$];
    logic [W-1:0] cur = '0;
    int           pos = 0;
    bit           busy_m = 0;

    // Observation of the serial streams
    logic [15:0]  cap_m = '0;
    logic [15:0]  cap_l = '0;
    int           nbeats = 0;
    int           nvalid = 0;
    bit           last_push = 0;

    always #5 clk = ~clk;

    piso_serializer #(.DATA_W(W), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1)) dut_m (
        .clk_i(clk), .rst_i(rst), .data_i(din), .valid_i(vin), .ready_o(m_ready),
        .data_o(m_data), .valid_o(m_valid), .last_o(m_last), .ready_i(rdy),
        .fill_o(m_fill), .busy_o(m_busy)
    );

    piso_serializer #(.DATA_W(W), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0)) dut_l (
        .clk_i(clk), .rst_i(rst), .data_i(din), .valid_i(vin), .ready_o(l_ready),
        .data_o(l_data), .valid_o(l_valid), .last_o(l_last), .ready_i(rdy),
        .fill_o(l_fill), .busy_o(l_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock: check outputs at negedge, advance model at posedge
    task automatic step();
        logic e_rdy, e_vld, e_last, e_dm, e_dl, p_push, p_beat;
        int   e_fill;
        @(negedge clk);
        e_rdy  = rst && (fq.size() < DEPTH);
        e_vld  = rst && busy_m;
        e_last = e_vld && (pos == W - 1);
        e_dm   = e_vld && cur[W-1-pos];
        e_dl   = e_vld && cur[pos];
        e_fill = rst ? fq.size() : 0;
        chk("ready_o", 32'(m_ready), 32'(e_rdy));
        chk("valid_o", 32'(m_valid), 32'(e_vld));
        chk("last_o",  32'(m_last),  32'(e_last));
        chk("fill_o",  32'(m_fill),  32'(e_fill));
        chk("busy_o",  32'(m_busy),  32'(e_vld));
        chk("data_o_msb", 32'(m_data), 32'(e_dm));
        chk("data_o_lsb", 32'(l_data), 32'(e_dl));
        chk("last_o_lsb", 32'(l_last), 32'(e_last));
        if (m_valid) nvalid++;
        if (m_valid && rdy) begin
            cap_m = {cap_m[14:0], m_data};
            cap_l = {cap_l[14:0], l_data};
            nbeats++;
        end
        p_push    = vin && e_rdy;
        p_beat    = e_vld && rdy;
        last_push = p_push;
        @(posedge clk);
        if (!rst) begin
            fq.delete();
            busy_m = 0;
            pos    = 0;
        end else begin
            if (!busy_m) begin
                if (fq.size() > 0) begin
                    cur    = fq.pop_front();
                    pos    = 0;
                    busy_m = 1;
                end
            end else if (p_beat) begin
                if (pos < W - 1) pos++;
                else if (fq.size() > 0) begin
                    cur = fq.pop_front();
                    pos = 0;
                end else busy_m = 0;
            end
            if (p_push) fq.push_back(din);
        end
        #1;
    endtask

    task automatic cyc(input logic r, input logic v, input logic [W-1:0] d, input logic rd);
        rst = r;
        vin = v;
        din = d;
        rdy = rd;
        step();
    endtask

    task automatic clr_obs();
        cap_m  = '0;
        cap_l  = '0;
        nbeats = 0;
        nvalid = 0;
    endtask

    initial begin
        logic [W-1:0] d6;
        bit           got6;

        // Reset held with a word offered
        repeat (3) cyc(1'b0, 1'b1, 8'hFF, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("post_reset_ready", 32'(m_ready), 32'd1);
        chk("post_reset_fill",  32'(m_fill),  32'd0);

        // Bit order
        clr_obs();
        cyc(1'b1, 1'b1, 8'hC1, 1'b1);
        repeat (12) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        chk("order_msb", 32'(cap_m[7:0]), 32'hC1);
        chk("order_lsb", 32'(cap_l[7:0]), 32'h83);
        chk("order_beats", 32'(nbeats), 32'd8);

        // Back-pressure for 3 cycles after bit 3
        clr_obs();
        cyc(1'b1, 1'b1, 8'hC1, 1'b1);
        cyc(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (3) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (10) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        chk("bp_word", 32'(cap_m[7:0]), 32'hC1);
        chk("bp_beats", 32'(nbeats), 32'd8);
        chk("bp_valid_cycles", 32'(nvalid), 32'd11);

        // Fill up with the shifter stalled
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, W'($urandom), 1'b0);
        d6 = $urandom;
        cyc(1'b1, 1'b1, d6, 1'b0);
        chk("full_fill",  32'(m_fill),  32'd4);
        chk("full_ready", 32'(m_ready), 32'd0);
        got6 = 0;
        for (int i = 0; i < 20 && !got6; i++) begin
            cyc(1'b1, 1'b1, d6, 1'b1);
            got6 = last_push;
        end
        chk("full_sixth_accepted", 32'(got6), 32'd1);
        repeat (50) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        chk("drain_fill", 32'(m_fill), 32'd0);
        chk("drain_busy", 32'(m_busy), 32'd0);

        // Back-to-back words
        clr_obs();
        cyc(1'b1, 1'b1, 8'hA5, 1'b1);
        cyc(1'b1, 1'b1, 8'h3C, 1'b1);
        repeat (20) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        chk("b2b_msb", 32'(cap_m), 32'hA53C);
        chk("b2b_lsb", 32'(cap_l), 32'hA53C);
        chk("b2b_valid_cycles", 32'(nvalid), 32'd16);

        // Reset in the middle of a word with more queued
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, W'($urandom), 1'b0);
        repeat (4) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("midrst_valid", 32'(m_valid), 32'd0);
        chk("midrst_fill",  32'(m_fill),  32'd0);
        clr_obs();
        repeat (6) cyc(1'b1, 1'b0, 8'h00, 1'b1);
        chk("midrst_no_stale", 32'(nvalid), 32'd0);

        // Random traffic with occasional reset
        for (int i = 0; i < 500; i++)
            cyc(($urandom_range(0, 79) != 0), 1'($urandom_range(0, 1)), W'($urandom),
                ($urandom_range(0, 3) != 0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
